// File: rtl/res_station_alu.sv
// Four-entry ALU reservation station for the Tomasulo core.
// Holds dispatched instructions until both operands are present, snoops
// the CDB for missing operands, issues the lowest-indexed ready entry to a
// single-cycle ALU and presents results through a valid/ready result port.
// An entry stays busy until its result has been accepted downstream.
module res_station_alu #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 3
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             disp_valid,
   output logic             disp_ready,
   input  logic [1:0]       disp_op,
   input  logic [3:0]       disp_dest,
   input  logic [15:0]      disp_vj,
   input  logic [15:0]      disp_vk,
   input  logic [TAG_W-1:0] disp_qj,
   input  logic [TAG_W-1:0] disp_qk,
   output logic [TAG_W-1:0] disp_tag,
   input  logic             cdb_valid,
   input  logic [TAG_W-1:0] cdb_tag,
   input  logic [15:0]      cdb_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [TAG_W-1:0] out_tag,
   output logic [3:0]       out_dest,
   output logic [15:0]      out_data
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

   localparam logic [TAG_W-1:0] TAG_NONE = {TAG_W{1'b0}};

   // Single-cycle ALU; arithmetic wraps modulo 2^16.
   function automatic logic [15:0] alu_calc(input logic [1:0] op,
                                            input logic [15:0] a,
                                            input logic [15:0] b);
      logic [15:0] r;
      case (op)
         OP_ADD:  r = a + b;
         OP_SUB:  r = a - b;
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         default: r = 16'h0000;
      endcase
      return r;
   endfunction

   // A waiting operand matches a broadcast only for a non-zero tag.
   function automatic logic tag_hit(input logic             valid,
                                    input logic [TAG_W-1:0] q,
                                    input logic [TAG_W-1:0] tag);
      return valid && (q != TAG_NONE) && (q == tag);
   endfunction

   // Entry storage
   logic             busy_r   [DEPTH];
   logic             issued_r [DEPTH];
   logic [1:0]       op_r     [DEPTH];
   logic [3:0]       dest_r   [DEPTH];
   logic [15:0]      vj_r     [DEPTH];
   logic [15:0]      vk_r     [DEPTH];
   logic [TAG_W-1:0] qj_r     [DEPTH];
   logic [TAG_W-1:0] qk_r     [DEPTH];

   // Result register
   logic             out_valid_r;
   logic [TAG_W-1:0] out_tag_r;
   logic [3:0]       out_dest_r;
   logic [15:0]      out_data_r;

   // Control
   logic             alloc_found_s;
   logic [IDX_W-1:0] alloc_idx_s;
   logic             issue_found_s;
   logic [IDX_W-1:0] issue_idx_s;
   logic             disp_fire_s;
   logic             issue_fire_s;
   logic             drain_s;
   logic [IDX_W-1:0] free_idx_s;
   logic [15:0]      alu_res_s;

   // Pick the lowest free slot for allocation and the lowest ready slot for issue.
   always_comb begin
      alloc_found_s = 1'b0;
      alloc_idx_s   = {IDX_W{1'b0}};
      issue_found_s = 1'b0;
      issue_idx_s   = {IDX_W{1'b0}};
      for (int i = DEPTH - 1; i >= 0; i--) begin
         alloc_found_s = !busy_r[i] ? 1'b1 : alloc_found_s;
         alloc_idx_s   = !busy_r[i] ? IDX_W'(i) : alloc_idx_s;
         issue_found_s = (busy_r[i] && !issued_r[i] &&
                          (qj_r[i] == TAG_NONE) && (qk_r[i] == TAG_NONE))
                         ? 1'b1 : issue_found_s;
         issue_idx_s   = (busy_r[i] && !issued_r[i] &&
                          (qj_r[i] == TAG_NONE) && (qk_r[i] == TAG_NONE))
                         ? IDX_W'(i) : issue_idx_s;
      end
   end

   // Handshake qualifiers and the ALU result for the selected entry.
   always_comb begin
      disp_fire_s  = disp_valid && alloc_found_s;
      issue_fire_s = issue_found_s && (!out_valid_r || out_ready);
      drain_s      = out_valid_r && out_ready;
      free_idx_s   = IDX_W'(out_tag_r - TAG_W'(1));
      alu_res_s    = alu_calc(op_r[issue_idx_s], vj_r[issue_idx_s], vk_r[issue_idx_s]);
   end

   assign disp_ready = alloc_found_s;
   assign disp_tag   = alloc_found_s ? (TAG_W'(alloc_idx_s) + TAG_W'(1)) : TAG_NONE;

   // Entry state: dispatch write with bypass, CDB snoop, issue mark and free.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            busy_r[i]   <= 1'b0;
            issued_r[i] <= 1'b0;
            op_r[i]     <= 2'b00;
            dest_r[i]   <= 4'h0;
            vj_r[i]     <= 16'h0000;
            vk_r[i]     <= 16'h0000;
            qj_r[i]     <= TAG_NONE;
            qk_r[i]     <= TAG_NONE;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (disp_fire_s && (alloc_idx_s == IDX_W'(i))) begin
               busy_r[i]   <= 1'b1;
               issued_r[i] <= 1'b0;
               op_r[i]     <= disp_op;
               dest_r[i]   <= disp_dest;
               if (tag_hit(cdb_valid, disp_qj, cdb_tag)) begin
                  vj_r[i] <= cdb_data;
                  qj_r[i] <= TAG_NONE;
               end else begin
                  vj_r[i] <= disp_vj;
                  qj_r[i] <= disp_qj;
               end
               if (tag_hit(cdb_valid, disp_qk, cdb_tag)) begin
                  vk_r[i] <= cdb_data;
                  qk_r[i] <= TAG_NONE;
               end else begin
                  vk_r[i] <= disp_vk;
                  qk_r[i] <= disp_qk;
               end
            end else begin
               if (drain_s && (free_idx_s == IDX_W'(i))) begin
                  busy_r[i]   <= 1'b0;
                  issued_r[i] <= 1'b0;
               end else if (issue_fire_s && (issue_idx_s == IDX_W'(i))) begin
                  issued_r[i] <= 1'b1;
               end
               if (busy_r[i] && tag_hit(cdb_valid, qj_r[i], cdb_tag)) begin
                  vj_r[i] <= cdb_data;
                  qj_r[i] <= TAG_NONE;
               end
               if (busy_r[i] && tag_hit(cdb_valid, qk_r[i], cdb_tag)) begin
                  vk_r[i] <= cdb_data;
                  qk_r[i] <= TAG_NONE;
               end
            end
         end
      end
   end

   // Result register: reload on issue (even while draining), else clear valid on drain.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         out_valid_r <= 1'b0;
         out_tag_r   <= TAG_NONE;
         out_dest_r  <= 4'h0;
         out_data_r  <= 16'h0000;
      end else if (issue_fire_s) begin
         out_valid_r <= 1'b1;
         out_tag_r   <= TAG_W'(issue_idx_s) + TAG_W'(1);
         out_dest_r  <= dest_r[issue_idx_s];
         out_data_r  <= alu_res_s;
      end else if (drain_s) begin
         out_valid_r <= 1'b0;
      end
   end

   assign out_valid = out_valid_r;
   assign out_tag   = out_tag_r;
   assign out_dest  = out_dest_r;
   assign out_data  = out_data_r;

endmodule

// File: doc/res_station_alu.md
# res_station_alu

Four-entry reservation station for the ALU in the Tomasulo core, receiving end of the heap dispatch interface. It accepts dispatched instructions with operand values or producer tags, snoops the common data bus (CDB) for missing operands, and issues the lowest-indexed ready entry to a single-cycle ALU. Results leave through a valid/ready result port that the top level drives onto the CDB. An entry is freed only when its result has been taken.

## Interface
- DEPTH, 4: number of entries; tag of entry i is i+1, and tag 0 means "operand present".
- TAG_W, 3: tag width; must hold DEPTH.
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- disp_valid  in  1  heap presents an instruction
- disp_ready  out  1  at least one free entry
- disp_op  in  2  00 ADD, 01 SUB, 10 AND, 11 OR
- disp_dest  in  4  destination register address
- disp_vj, disp_vk  in  16  operand values, valid when matching q is 0
- disp_qj, disp_qk  in  TAG_W  producer tags, 0 = value present
- disp_tag  out  TAG_W  tag the current dispatch will receive; 0 when full
- cdb_valid  in  1  CDB broadcast this cycle
- cdb_tag  in  TAG_W  producing tag
- cdb_data  in  16  broadcast value
- out_valid  out  1  result register holds a result
- out_ready  in  1  consumer/CDB accepts result
- out_tag  out  TAG_W  tag of the producing entry
- out_dest  out  4  destination register
- out_data  out  16  result

## Operation
- Entry state: busy, issued, op, dest, vj, qj, vk, qk.
- Allocation: the lowest-index non-busy entry. disp_ready = any entry not busy. disp_tag = index+1 of that entry, else 0. Combinational.
- Dispatch fires on disp_valid & disp_ready. It writes the entry with busy=1 and issued=0.
- Dispatch bypass: if cdb_valid and disp_qj == cdb_tag with qj ≠ 0, store vj = cdb_data and qj = 0. The same rule applies to qk.
- CDB snoop: each busy entry with qj == cdb_tag ≠ 0 while cdb_valid captures vj = cdb_data and sets qj = 0. The same rule applies to qk. A tag of 0 never matches.
- Ready entry: busy & !issued & qj==0 & qk==0.
- Issue: the lowest-index ready entry is selected. It loads the result register when !out_valid or out_ready. The entry is marked issued.
- ALU results, 16-bit:
  - ADD: vj+vk modulo 2^16, carry dropped.
  - SUB: vj−vk modulo 2^16.
  - AND: bitwise AND.
  - OR: bitwise OR.
- Free: on out_valid & out_ready, the entry with tag out_tag clears busy and issued.
- Simultaneous free and dispatch:
  - disp_ready is computed from state before the edge, so a full station stays not-ready that cycle.
  - A freed entry is allocatable from the next cycle.
- Simultaneous drain and issue: the result register reloads in the same edge. out_valid stays 1 with the new contents.
- Reset (async, resetn=0):
  - All entries are cleared.
  - out_valid=0; out_tag, out_dest and out_data are 0.
  - disp_ready=1 and disp_tag=1 while in reset.
  - An in-flight result is discarded.

## Timing
- Dispatch is accepted at edge N with both operands present. The entry becomes ready in cycle N+1 and issues at edge N+1. out_valid is high after edge N+1, giving 2-cycle minimum latency.
- A CDB capture at edge N makes the entry ready in cycle N+1.
- Throughput is one result per cycle while out_ready=1 and ready entries exist.
- out_* hold stable while out_valid & !out_ready.
- Issue order is lowest index first, not age. A younger entry in a lower slot may overtake an older one.

## Test plan
- Reset then dispatch ADD with vj=0x0003, vk=0x0004 and qj=qk=0, out_ready=1. Required: disp_tag=1, out_valid after 2 edges, out_data=0x0007, out_tag=1, entry freed next cycle.
- Wrap: ADD 0xFFFF+0x0002 gives 0x0001. SUB 0x0000−0x0001 gives 0xFFFF.
- Dependency: dispatch SUB with qj=2, vk=0x0005, then pulse the CDB with tag 2 and data 0x0010. Required: out_data=0x000B exactly 2 edges after the CDB pulse. A bypass variant with the CDB in the dispatch cycle gives the same result.
- Fill: 4 dispatches with out_ready=0 and all operands present. Required: disp_tag 1,2,3,4, then disp_ready=0 and disp_tag=0. out_* stay at entry 1's result. Raising out_ready drains tags 1,2,3,4 in consecutive cycles, and disp_ready returns 1 the cycle after the first drain.
- Stall with reset: out_valid=1 and out_ready=0 for 5 cycles, out_* stable. Assert resetn=0 mid-stall. Required: out_valid=0 immediately (async), disp_ready=1, and all entries empty after release.
